mips_fetch_unit: RTL
====================

Name: mips_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers the returned word in a single-entry instruction register and presents it to decode with valid/ready; the decoder's op field is instr[31:26].
- Branch/jump redirects from the datapath squash in-flight or buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- INSTR_W, 32, instruction and address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  32  byte address of request; always word aligned.
- imem_rsp_valid  in  1  response data valid; at most one per accepted request.
- imem_rsp_data  in  32  returned instruction word.
- redirect  in  1  datapath branch-taken or jump this cycle.
- redirect_pc  in  32  target PC; bits [1:0] ignored and forced to 0.
- instr_valid  out  1  instr register holds a deliverable instruction.
- instr_ready  in  1  decode consumes instr this cycle.
- instr  out  32  buffered instruction; instr[31:26] feeds decoder op.
- instr_pc  out  32  PC of buffered instruction.
- pcplus4  out  32  instr_pc + 4, modulo 2^32.
- fetch_count  out  32  number of instructions delivered (valid&ready), wraps.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, pcplus4=0, instr_valid=0, squash=0, fetch_count=0, imem_req_valid=0.
- IDLE: first clock after reset release moves to REQ; no request is issued in IDLE.
- REQ: imem_req_valid = !redirect; imem_addr=pc.
  - On valid&ready → WAIT.
  - On redirect: pc<=redirect_pc&~3, stay REQ, no request that cycle.
- WAIT: imem_req_valid=0.
  - rsp_valid with squash=0 and no redirect: instr<=rsp_data, instr_pc<=pc, pcplus4<=pc+4, pc<=pc+4, instr_valid<=1 → FULL.
  - rsp_valid with squash=1: drop the word, squash<=0 → REQ.
  - redirect without rsp_valid: pc<=target, squash<=1, stay WAIT.
  - redirect and rsp_valid in the same cycle: drop the word, pc<=target, squash<=0 → REQ.
- FULL: instr_valid=1; outputs held stable while instr_ready=0.
  - instr_ready=1 and no redirect: fetch_count++, instr_valid<=0 → REQ.
  - redirect (with or without ready): instr_valid<=0, pc<=target → REQ. Count increments only if ready=1 that cycle, because the instruction was delivered.
- Only one outstanding request. rsp_valid outside WAIT is ignored. Best-case throughput is 1 instruction per 3 cycles with zero-latency memory.
- PC arithmetic is unsigned 32-bit; 32'hFFFF_FFFC+4 wraps to 0.
- A reset asserted mid-WAIT abandons the request; any late response after reset is ignored because state≠WAIT.

Decomposition:
- Shared package mips_pkg holds:
  - fetch_state_t enum {IDLE, REQ, WAIT, FULL}
  - INSTR_W and PC_STEP=4
  - opcode localparams OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_ADDI=6'b001000, OP_J=6'b000010, for decode and bench reuse.
- One sub-module: mips_pc_reg, a 32-bit async-low-reset register with load enable and reset value parameter. It is used for pc.

Test Plan:
- Reset then memory always ready, one-cycle response returning 32'h8C080004 (LW) at addr 0 → instr_valid in cycle 3 after release, instr=32'h8C080004, instr_pc=0, pcplus4=4; the next request uses addr 4.
- instr_ready held 0 for 5 cycles in FULL → instr/instr_pc stable, no new imem_req_valid, fetch_count unchanged; ready=1 → fetch_count=1.
- Redirect to 32'h0000_0043 while in WAIT, then response 32'h12345678 arrives → word dropped, instr_valid stays 0, next imem_addr=32'h0000_0040.
- Redirect and rsp_valid in the same cycle → response dropped, next request at target, squash clear (next response 32'h20080005 is delivered).
- Redirect in FULL with instr_ready=1 → fetch_count increments once, next request at target; with ready=0, count unchanged.
- PC=32'hFFFF_FFFC fetch delivered → pcplus4=0 and next imem_addr=0; assert reset_n low during WAIT, late rsp_valid ignored, restart at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//
// Shared definitions for the MIPS front end: the fetch-stage state encoding,
// the datapath width, the PC increment and the primary opcode values that
// decode (and any bench) can reuse.
//
// Contents:
//   fetch_state_t  IDLE / REQ / WAIT / FULL states of the fetch unit
//   INSTR_W        instruction and address width in bits
//   PC_STEP        byte distance between consecutive instructions
//   OP_*           6-bit primary opcodes found in instr[31:26]
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;

  // IDLE  : one-cycle holding state right after reset release
  // REQ   : presenting a request to instruction memory
  // WAIT  : request accepted, waiting for the single response
  // FULL  : instruction register holds a word for decode
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/mips_pc_reg.sv
// ---------------------------------------------------------------------------
// mips_pc_reg
//
// Program-counter register: a WIDTH-bit register with an asynchronous
// active-low reset to RESET_VAL and a synchronous load enable. Holds its
// value whenever load_i is low.
//
// Ports:
//   clk_i   in   1      clock, rising edge
//   rst_ni  in   1      asynchronous active-low reset
//   load_i  in   1      capture d_i on the next rising edge
//   d_i     in   WIDTH  next value
//   q_o     out  WIDTH  current value
// ---------------------------------------------------------------------------
module mips_pc_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Keep the old value unless a load is requested.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= RESET_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign q_o = value_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit
//
// Instruction-fetch stage feeding the main decoder. Owns the PC, issues one
// instruction-memory request at a time over valid/ready, buffers the returned
// word in a single-entry instruction register and hands it to decode over
// valid/ready. Branch/jump redirects from the datapath squash any in-flight
// or buffered fetch and restart fetching at the (word-aligned) target.
//
// Ports:
//   clk             in   1   system clock, rising edge
//   reset_n         in   1   asynchronous active-low reset
//   imem_req_valid  out  1   fetch request valid
//   imem_req_ready  in   1   memory accepts the request this cycle
//   imem_addr       out  W   word-aligned byte address of the request
//   imem_rsp_valid  in   1   response valid (one per accepted request)
//   imem_rsp_data   in   W   returned instruction word
//   redirect        in   1   branch taken / jump this cycle
//   redirect_pc     in   W   redirect target (bits [1:0] ignored)
//   instr_valid     out  1   instruction register holds a deliverable word
//   instr_ready     in   1   decode consumes instr this cycle
//   instr           out  W   buffered instruction (op field is [31:26])
//   instr_pc        out  W   PC of the buffered instruction
//   pcplus4         out  W   instr_pc + 4, modulo 2^W
//   fetch_count     out  32  instructions delivered to decode, wraps
// ---------------------------------------------------------------------------
module mips_fetch_unit #(
  parameter int                 INSTR_W  = 32,
  parameter logic [INSTR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] instr_pc,
  output logic [INSTR_W-1:0] pcplus4,
  output logic [31:0]        fetch_count
);

  import mips_pkg::*;

  localparam logic [INSTR_W-1:0] LowBitsMask  = INSTR_W'(3);
  localparam logic [INSTR_W-1:0] AlignedReset = RESET_PC & ~LowBitsMask;
  localparam logic [INSTR_W-1:0] Step         = INSTR_W'(PC_STEP);

  fetch_state_t state_q, state_d;

  logic [INSTR_W-1:0] pc_q;
  logic [INSTR_W-1:0] pc_d;
  logic               pcLoad;

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] instrPc_q, instrPc_d;
  logic [INSTR_W-1:0] pcPlus4_q, pcPlus4_d;
  logic               instrValid_q, instrValid_d;
  logic               squash_q, squash_d;
  logic [31:0]        fetchCount_q, fetchCount_d;

  logic [INSTR_W-1:0] redirectTarget;
  logic [INSTR_W-1:0] pcNext;
  logic               delivered;

  assign redirectTarget = redirect_pc & ~LowBitsMask;
  assign pcNext         = pc_q + Step;
  assign delivered      = (state_q == FULL) && instr_ready;

  mips_pc_reg #(
    .WIDTH     (INSTR_W),
    .RESET_VAL (AlignedReset)
  ) u_pc_reg (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .load_i (pcLoad),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  // Next-state logic. squash remembers that a redirect arrived while a
  // request was outstanding, so the stale response that is still coming
  // back from memory gets dropped instead of delivered.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pcLoad       = 1'b0;
    instr_d      = instr_q;
    instrPc_d    = instrPc_q;
    pcPlus4_d    = pcPlus4_q;
    instrValid_d = instrValid_q;
    squash_d     = squash_q;
    fetchCount_d = fetchCount_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        if (redirect) begin
          pc_d   = redirectTarget;
          pcLoad = 1'b1;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect) begin
            // The returning word belongs to the old path; the target is
            // fetched fresh, so nothing is left to squash.
            pc_d     = redirectTarget;
            pcLoad   = 1'b1;
            squash_d = 1'b0;
            state_d  = REQ;
          end else if (squash_q) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            instr_d      = imem_rsp_data;
            instrPc_d    = pc_q;
            pcPlus4_d    = pcNext;
            pc_d         = pcNext;
            pcLoad       = 1'b1;
            instrValid_d = 1'b1;
            state_d      = FULL;
          end
        end else if (redirect) begin
          pc_d     = redirectTarget;
          pcLoad   = 1'b1;
          squash_d = 1'b1;
        end
      end

      FULL: begin
        // A delivery in the same cycle as a redirect still counts: decode
        // took the word before the redirect threw the buffer away.
        if (delivered) begin
          fetchCount_d = fetchCount_q + 32'd1;
        end
        if (redirect) begin
          pc_d         = redirectTarget;
          pcLoad       = 1'b1;
          instrValid_d = 1'b0;
          state_d      = REQ;
        end else if (instr_ready) begin
          instrValid_d = 1'b0;
          state_d      = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered state; reset abandons any outstanding request because the
  // FSM leaves WAIT, so a late response is simply ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      instrPc_q    <= '0;
      pcPlus4_q    <= '0;
      instrValid_q <= 1'b0;
      squash_q     <= 1'b0;
      fetchCount_q <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      instrPc_q    <= instrPc_d;
      pcPlus4_q    <= pcPlus4_d;
      instrValid_q <= instrValid_d;
      squash_q     <= squash_d;
      fetchCount_q <= fetchCount_d;
    end
  end

  // A redirect in REQ retargets the PC instead of issuing the stale address.
  assign imem_req_valid = (state_q == REQ) && !redirect;
  assign imem_addr      = pc_q;
  assign instr_valid    = instrValid_q;
  assign instr          = instr_q;
  assign instr_pc       = instrPc_q;
  assign pcplus4        = pcPlus4_q;
  assign fetch_count    = fetchCount_q;

endmodule
